sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO with flop-array storage, fill-level count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. Read mode is selectable at elaboration: registered-read (standard) or first-word-fall-through (FWFT). It is the single-clock successor to the dual-clock FIFO top. It serves same-domain buffering where no pointer synchronisers are needed.

---
 rtl/sync_fifo_ctrl_if.sv | 37 +++
 rtl/sync_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_ctrl_if
//  Brief    : Write/read handshake, status and error bundle for sync_fifo_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface sync_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 9
);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output w_en, w_data, r_en, clr_err,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, w_data, r_en, clr_err,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_ctrl
//  Brief    : Single-clock flop-array FIFO with registered status flags, sticky
//             error flags and elaboration-time standard/FWFT read mode.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 9,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);

    localparam int c_depth = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_wptr_nxt;
    logic [ADDR_WIDTH:0]   w_rptr_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Pointers carry one extra wrap bit, so their difference is the fill level
    // 0..DEPTH and flags can be derived from the post-edge value.
    always_comb begin
        w_wr_ok     = bus.w_en & ~r_full;
        w_rd_ok     = bus.r_en & ~r_empty;
        w_wptr_nxt  = w_wr_ok ? r_wptr + c_one : r_wptr;
        w_rptr_nxt  = w_rd_ok ? r_rptr + c_one : r_rptr;
        w_count_nxt = w_wptr_nxt - w_rptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= (AFULL_THRESH <= 0);
            r_aempty <= (AEMPTY_THRESH >= 0);
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (int'(w_count_nxt) == c_depth);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (int'(w_count_nxt) >= AFULL_THRESH);
            r_aempty <= (int'(w_count_nxt) <= AEMPTY_THRESH);
            // A new error on the same edge as CLR_ERR keeps the flag set.
            if (bus.w_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end
            if (bus.r_en && r_empty) begin
                r_unf <= 1'b1;
            end else if (bus.clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    // Storage is never cleared; writes are simply blocked in the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= bus.w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so
            // R_DATA reads back as zero after reset.
            assign bus.r_data  = r_empty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];
            assign bus.r_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rdata;
            logic                  r_rvalid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
                    end
                end
            end

            assign bus.r_data  = r_rdata;
            assign bus.r_valid = r_rvalid;
        end
    endgenerate

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_ctrl
//  Brief    : Queue-model scoreboard bench for standard and FWFT instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_s;
    logic rst_f;

    int checks = 0;
    int errors = 0;

    // Reference state for the standard instance
    logic [DW-1:0] sq[$];
    logic [DW-1:0] exp_q[$];
    bit            s_ovf;
    bit            s_unf;
    logic [DW-1:0] s_last;
    bit            mon_en = 1'b0;

    // Reference state for the FWFT instance
    logic [DW-1:0] fq[$];

    sync_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    sync_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f_if ();

    sync_fifo_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(4),
        .AEMPTY_THRESH(4), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst_s), .bus(s_if.slave)
    );

    sync_fifo_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(4),
        .AEMPTY_THRESH(4), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst_f), .bus(f_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One standard-mode cycle: drive, advance the queue model, compare status.
    task automatic drv_s(input bit r, input bit we, input logic [DW-1:0] wd,
                         input bit re, input bit ce);
        bit full_m;
        bit empty_m;
        @(negedge clk);
        rst_s        = r;
        s_if.w_en    = we;
        s_if.w_data  = wd;
        s_if.r_en    = re;
        s_if.clr_err = ce;
        if (r) begin
            sq.delete();
            exp_q.delete();
            s_ovf  = 1'b0;
            s_unf  = 1'b0;
            s_last = '0;
        end else begin
            full_m  = (sq.size() == DEPTH);
            empty_m = (sq.size() == 0);
            if (re && !empty_m) exp_q.push_back(sq.pop_front());
            if (we && !full_m)  sq.push_back(wd);
            if (we && full_m) s_ovf = 1'b1;
            else if (ce)      s_ovf = 1'b0;
            if (re && empty_m) s_unf = 1'b1;
            else if (ce)       s_unf = 1'b0;
        end
        @(posedge clk);
        #1;
        if (r) mon_en = 1'b1;
        chk("s_count",  int'(s_if.count), sq.size());
        chk("s_full",   int'(s_if.full),  int'(sq.size() == DEPTH));
        chk("s_empty",  int'(s_if.empty), int'(sq.size() == 0));
        chk("s_afull",  int'(s_if.almost_full),  int'(sq.size() >= 4));
        chk("s_aempty", int'(s_if.almost_empty), int'(sq.size() <= 4));
        chk("s_ovf",    int'(s_if.overflow),  int'(s_ovf));
        chk("s_unf",    int'(s_if.underflow), int'(s_unf));
    endtask

    // Read-data monitor: each accepted read must appear exactly one cycle later.
    initial begin
        logic [DW-1:0] d;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    d = exp_q.pop_front();
                    chk("s_r_valid", int'(s_if.r_valid), 1);
                    chk("s_r_data",  int'(s_if.r_data),  int'(d));
                    s_last = d;
                end else begin
                    chk("s_r_valid_idle", int'(s_if.r_valid), 0);
                    chk("s_r_data_hold",  int'(s_if.r_data),  int'(s_last));
                end
            end
        end
    end

    task automatic drv_f(input bit r, input bit we, input logic [DW-1:0] wd,
                         input bit re);
        @(negedge clk);
        rst_f        = r;
        f_if.w_en    = we;
        f_if.w_data  = wd;
        f_if.r_en    = re;
        f_if.clr_err = 1'b0;
        if (r) begin
            fq.delete();
        end else begin
            if (re && fq.size() > 0) void'(fq.pop_front());
            if (we && fq.size() < DEPTH) fq.push_back(wd);
        end
        @(posedge clk);
        #1;
        chk("f_count",   int'(f_if.count),   fq.size());
        chk("f_empty",   int'(f_if.empty),   int'(fq.size() == 0));
        chk("f_r_valid", int'(f_if.r_valid), int'(fq.size() > 0));
        if (fq.size() > 0) chk("f_r_data", int'(f_if.r_data), int'(fq[0]));
        if (r) begin
            chk("f_rst_r_data", int'(f_if.r_data),       0);
            chk("f_rst_full",   int'(f_if.full),         0);
            chk("f_rst_aempty", int'(f_if.almost_empty), 1);
            chk("f_rst_afull",  int'(f_if.almost_full),  0);
            chk("f_rst_ovf",    int'(f_if.overflow),     0);
            chk("f_rst_unf",    int'(f_if.underflow),    0);
        end
    endtask

    initial begin
        int  wr_acc;
        bit  we;
        bit  re;
        rst_s = 1'b1;
        rst_f = 1'b1;
        s_if.w_en = 1'b0; s_if.w_data = '0; s_if.r_en = 1'b0; s_if.clr_err = 1'b0;
        f_if.w_en = 1'b0; f_if.w_data = '0; f_if.r_en = 1'b0; f_if.clr_err = 1'b0;

        // Reset (inputs active in the reset cycle must be ignored) then idle
        drv_s(1, 1, 8'h55, 1, 0);
        drv_s(1, 0, 8'h00, 0, 0);
        repeat (10) drv_s(0, 0, 8'h00, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) drv_s(0, 1, 8'(i), 0, 0);
        drv_s(0, 1, 8'hFF, 0, 0);
        repeat (8) drv_s(0, 0, 8'h00, 1, 0);
        drv_s(0, 0, 8'h00, 0, 0);
        drv_s(0, 0, 8'h00, 0, 1);

        // Underflow, clear, clear coincident with new underflow
        drv_s(0, 0, 8'h00, 1, 0);
        drv_s(0, 0, 8'h00, 0, 1);
        drv_s(0, 0, 8'h00, 1, 1);
        drv_s(0, 0, 8'h00, 0, 1);

        // Simultaneous read and write at COUNT=3
        for (int i = 0; i < 3; i++) drv_s(0, 1, 8'h10 + 8'(i), 0, 0);
        drv_s(0, 1, 8'h13, 1, 0);
        repeat (3) drv_s(0, 0, 8'h00, 1, 0);
        drv_s(0, 0, 8'h00, 0, 0);

        // Simultaneous at COUNT=0
        drv_s(0, 1, 8'h20, 1, 0);
        drv_s(0, 0, 8'h00, 1, 1);
        drv_s(0, 0, 8'h00, 0, 0);

        // Simultaneous at COUNT=DEPTH
        for (int i = 0; i < 8; i++) drv_s(0, 1, 8'h30 + 8'(i), 0, 0);
        drv_s(0, 1, 8'h40, 1, 0);
        repeat (7) drv_s(0, 0, 8'h00, 1, 0);
        drv_s(0, 0, 8'h00, 0, 1);

        // Random stream of 100 accepted writes across pointer wrap
        wr_acc = 0;
        for (int cyc = 0; cyc < 3000 && wr_acc < 100; cyc++) begin
            we = ($urandom_range(0, 9) < 6);
            re = ($urandom_range(0, 9) < 5);
            if (we && sq.size() < DEPTH) wr_acc++;
            drv_s(0, we, 8'($urandom), re, ($urandom_range(0, 9) == 0));
        end
        if (wr_acc < 100) chk("stream_budget", wr_acc, 100);
        for (int k = 0; k < 2 * DEPTH && sq.size() > 0; k++) drv_s(0, 0, 8'h00, 1, 0);
        drv_s(0, 0, 8'h00, 0, 1);
        drv_s(0, 0, 8'h00, 0, 0);
        chk("s_scoreboard_drained", exp_q.size(), 0);

        // FWFT instance
        drv_f(1, 0, 8'h00, 0);
        drv_f(0, 1, 8'hA5, 0);
        drv_f(0, 0, 8'h00, 1);
        drv_f(0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) drv_f(0, 1, 8'($urandom), 0);
        drv_f(0, 0, 8'h00, 1);
        drv_f(0, 1, 8'h6E, 0);
        drv_f(1, 1, 8'h77, 0);
        drv_f(0, 0, 8'h00, 0);
        drv_f(0, 1, 8'h3C, 0);
        drv_f(0, 1, 8'h3D, 1);
        drv_f(0, 0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
